// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: MEM/WB write-back control bundle and default widths.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    // Field order matches wbcntrlsig: [1]=RegWrite, [0]=MemToReg
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_select.sv
// MemToReg write-back mux, shared by the register file and the forwarding unit.
module wb_select #(
    parameter int DATA_W = 32
) (
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = memtoreg ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back select, 32-entry register file, forwarding taps, write counter.
// Define WB_BYPASS_EN to let both read ports see a same-cycle write ahead of the array.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = 32,
    parameter int ADDR_W = $clog2(NREG),
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] addresss_in,
    input  logic [ADDR_W-1:0] inst2_in,
    input  logic [1:0]        wbcntrlsig_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              wb_regwrite,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    wb_ctrl_t          ctrl;
    logic [DATA_W-1:0] regs [NREG];

    assign ctrl = wb_ctrl_t'(wbcntrlsig_in);

    wb_select #(
        .DATA_W(DATA_W)
    ) u_wb_select (
        .memtoreg(ctrl.memtoreg),
        .mem_data(read_data_in),
        .alu_data(addresss_in),
        .wb_data (wb_data)
    );

    assign wb_dest     = inst2_in;
    assign wb_regwrite = ctrl.regwrite && (inst2_in != ZERO_IDX);

    // Reset wins over a write presented in the same cycle; r0 is never a target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wb_regwrite) begin
            regs[inst2_in] <= wb_data;
            wr_count       <= wr_count + 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == ZERO_IDX) begin
            rs_data = '0;
        end else if (wb_regwrite && (rs_addr == inst2_in)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == ZERO_IDX) begin
            rt_data = '0;
        end else if (wb_regwrite && (rt_addr == inst2_in)) begin
            rt_data = wb_data;
        end
    end
`else
    // Array-only reads: a same-cycle read of the write target sees the old value.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == ZERO_IDX) begin
            rs_data = '0;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == ZERO_IDX) begin
            rt_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (counter narrowed to 4 bits to exercise wrap).
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] read_data_in;
    logic [DATA_W-1:0] addresss_in;
    logic [ADDR_W-1:0] inst2_in;
    logic [1:0]        wbcntrlsig_in;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_regwrite;
    logic [CNT_W-1:0]  wr_count;

    int checks = 0;
    int errors = 0;

    wb_regfile #(
        .DATA_W(DATA_W),
        .NREG  (32),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read_data_in (read_data_in),
        .addresss_in  (addresss_in),
        .inst2_in     (inst2_in),
        .wbcntrlsig_in(wbcntrlsig_in),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ctrl, input logic [ADDR_W-1:0] dest,
                                 input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                                 input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        wbcntrlsig_in = ctrl;
        inst2_in      = dest;
        addresss_in   = alu;
        read_data_in  = mem;
        rs_addr       = ra;
        rt_addr       = rb;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] same_cycle_exp;

    initial begin
        // Reset held two cycles with a write to r5 presented throughout
        rst = 1'b1;
        applyStimulus(2'b10, 5'd5, 32'h0000_0055, 32'h0, 5'd5, 5'd5);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        applyStimulus(2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        checkOutput("reset_rs5", rs_data, 32'h0);
        checkOutput("reset_count", 32'(wr_count), 32'h0);
        checkOutput("reset_regwrite_off", 32'(wb_regwrite), 32'h0);
        nextCycle();

        // ALU write to r8
        applyStimulus(2'b10, 5'd8, 32'h0000_1234, 32'hCAFE_0000, 5'd8, 5'd8);
        @(negedge clk);
        checkOutput("alu_wb_data", wb_data, 32'h0000_1234);
        checkOutput("alu_wb_dest", 32'(wb_dest), 32'd8);
        checkOutput("alu_wb_regwrite", 32'(wb_regwrite), 32'h1);
`ifdef WB_BYPASS_EN
        same_cycle_exp = 32'h0000_1234;
`else
        same_cycle_exp = 32'h0;
`endif
        checkOutput("alu_same_cycle_rs8", rs_data, same_cycle_exp);
        nextCycle();
        applyStimulus(2'b00, 5'd8, 32'h0, 32'h0, 5'd8, 5'd0);
        @(negedge clk);
        checkOutput("alu_rs8", rs_data, 32'h0000_1234);
        checkOutput("alu_count", 32'(wr_count), 32'd1);
        nextCycle();

        // Load write to r9 selects memory data
        applyStimulus(2'b11, 5'd9, 32'h0000_0001, 32'hDEAD_BEEF, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("load_wb_data", wb_data, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(2'b00, 5'd9, 32'h0, 32'h0, 5'd9, 5'd8);
        @(negedge clk);
        checkOutput("load_rs9", rs_data, 32'hDEAD_BEEF);
        checkOutput("load_rt8", rt_data, 32'h0000_1234);
        checkOutput("load_count", 32'(wr_count), 32'd2);
        nextCycle();

        // MemToReg with RegWrite low: mux still selects, nothing commits
        applyStimulus(2'b01, 5'd9, 32'h1111_1111, 32'h2222_2222, 5'd9, 5'd9);
        @(negedge clk);
        checkOutput("nowrite_wb_data", wb_data, 32'h2222_2222);
        checkOutput("nowrite_regwrite", 32'(wb_regwrite), 32'h0);
        checkOutput("nowrite_rs9", rs_data, 32'hDEAD_BEEF);
        nextCycle();

        // r0 is never written and always reads zero
        applyStimulus(2'b10, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("r0_regwrite", 32'(wb_regwrite), 32'h0);
        checkOutput("r0_same_cycle_rs", rs_data, 32'h0);
        nextCycle();
        applyStimulus(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("r0_rs", rs_data, 32'h0);
        checkOutput("r0_rt", rt_data, 32'h0);
        checkOutput("r0_count", 32'(wr_count), 32'd2);
        nextCycle();

        // Same-cycle read of a register being overwritten (old value 7)
        applyStimulus(2'b10, 5'd10, 32'h0000_0007, 32'h0, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(2'b10, 5'd10, 32'hA5A5_A5A5, 32'h0, 5'd10, 5'd10);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        same_cycle_exp = 32'hA5A5_A5A5;
`else
        same_cycle_exp = 32'h0000_0007;
`endif
        checkOutput("same_cycle_rs10", rs_data, same_cycle_exp);
        checkOutput("same_cycle_rt10", rt_data, same_cycle_exp);
        nextCycle();
        applyStimulus(2'b00, 5'd10, 32'h0, 32'h0, 5'd10, 5'd10);
        @(negedge clk);
        checkOutput("after_rs10", rs_data, 32'hA5A5_A5A5);
        checkOutput("after_rt10", rt_data, 32'hA5A5_A5A5);
        checkOutput("after_count", 32'(wr_count), 32'd4);
        nextCycle();

        // Mid-stream reset with a write to r11 presented; everything clears
        rst = 1'b1;
        applyStimulus(2'b10, 5'd11, 32'h0000_0055, 32'h0, 5'd11, 5'd8);
        nextCycle();
        rst = 1'b0;
        applyStimulus(2'b00, 5'd11, 32'h0, 32'h0, 5'd11, 5'd8);
        @(negedge clk);
        checkOutput("midrst_rs11", rs_data, 32'h0);
        checkOutput("midrst_rt8", rt_data, 32'h0);
        checkOutput("midrst_count", 32'(wr_count), 32'h0);
        nextCycle();
        applyStimulus(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd10);
        @(negedge clk);
        checkOutput("midrst_rs9", rs_data, 32'h0);
        checkOutput("midrst_rt10", rt_data, 32'h0);
        nextCycle();

        // Counter wrap: 17 writes to r3 with idle RegWrite=0 cycles between
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(2'b10, 5'd3, 32'(i), 32'h0, 5'd3, 5'd0);
            nextCycle();
            applyStimulus(2'b00, 5'd3, 32'h0, 32'h0, 5'd3, 5'd0);
            @(negedge clk);
            if (i == 16) begin
                checkOutput("wrap_count_16", 32'(wr_count), 32'd0);
            end
            nextCycle();
        end
        @(negedge clk);
        checkOutput("wrap_count_17", 32'(wr_count), 32'd1);
        checkOutput("wrap_rs3", rs_data, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
